mem_block_clr: RTL and testbench

- Parametrised multi-port synchronous memory with:
  - per-port byte-lane write enables;
  - optional registered reads with write-first forwarding;
  - same-cycle write-conflict flag;
  - hardware clear sweep after reset.
- Successor to the team's basic multi-read/multi-write memory primitive.
- Serves as register file, CSR backing store or scratch RAM inside the RV32EC core.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_block_clr_if.sv | 35 +++
 rtl/mem_clear_seq.sv | 41 ++++
 rtl/mem_block_clr.sv | 108 ++++++++++
 tb/tb_mem_block_clr.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM type and byte-lane helpers for mem_block_clr
package mem_pkg;

    localparam int MAX_W = 256;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic {CLEAR, READY} clr_state_t;

    function automatic int lanes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Callers zero-extend to MAX_W and truncate the result back to their word width.
    function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] be,
                                                  input int byte_w);
        merge_be = old_w;
        for (int i = 0; i < MAX_W; i++)
            if (be[IDX_W'(i / byte_w)]) merge_be[i] = new_w[i];
    endfunction

endpackage

// File: rtl/mem_block_clr_if.sv
// mem_block_clr_if: read/write port bundle for mem_block_clr
interface mem_block_clr_if
    import mem_pkg::*;
#(
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int BYTE_W      = 8
);

    localparam int LANES = lanes(DATA_W, BYTE_W);

    logic [WRITE_PORTS-1:0]             wr_en;
    logic [WRITE_PORTS-1:0][ADDR_W-1:0] wr_addr;
    logic [WRITE_PORTS-1:0][DATA_W-1:0] wr_data;
    logic [WRITE_PORTS-1:0][LANES-1:0]  wr_be;
    logic [READ_PORTS-1:0]              rd_en;
    logic [READ_PORTS-1:0][ADDR_W-1:0]  rd_addr;
    logic [READ_PORTS-1:0][DATA_W-1:0]  rd_data;
    logic [READ_PORTS-1:0]              rd_valid;
    logic                               busy;
    logic                               wr_conflict;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, wr_conflict
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, busy, wr_conflict
    );

endinterface

// File: rtl/mem_clear_seq.sv
// mem_clear_seq: post-reset zero sweep over every memory word
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? CLEAR : READY;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        if (state == CLEAR) begin
            ptr_d = ptr + 1'b1;
            if (&ptr) state_d = READY;
        end
    end

    assign busy     = state == CLEAR;
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/mem_block_clr.sv
// mem_block_clr: multi-port byte-lane memory with optional registered reads and clear sweep
module mem_block_clr
    import mem_pkg::*;
#(
    parameter int READ_PORTS     = 2,
    parameter int WRITE_PORTS    = 1,
    parameter bit BUF_READ       = 1,
    parameter bit FWD            = 1,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int BYTE_W         = 8,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_block_clr_if.slave bus
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit USE_FWD = BUF_READ && FWD;

    if (DATA_W % BYTE_W != 0) begin : g_bad_lane
        $error("DATA_W must be a multiple of BYTE_W");
    end
    if (DATA_W > MAX_W) begin : g_bad_width
        $error("DATA_W exceeds mem_pkg::MAX_W");
    end

    logic [DATA_W-1:0]                 mem [DEPTH];
    logic [DATA_W-1:0]                 wr_word [WRITE_PORTS];
    logic [DATA_W-1:0]                 rd_word [READ_PORTS];
    logic [WRITE_PORTS-1:0]            wr_act;
    logic                              busy, clr_we, conf_d, conf_q;
    logic [ADDR_W-1:0]                 clr_addr;
    logic [READ_PORTS-1:0][DATA_W-1:0] rd_q;
    logic [READ_PORTS-1:0]             rd_v_q;

    mem_clear_seq #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_seq (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // Every port hitting one address computes the same fully merged word, so write order is irrelevant.
    always_comb begin
        conf_d = 1'b0;
        for (int p = 0; p < WRITE_PORTS; p++)
            wr_act[p] = bus.wr_en[p] && |bus.wr_be[p] && !busy;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wr_word[p] = mem[bus.wr_addr[p]];
            for (int q = 0; q < WRITE_PORTS; q++)
                if (wr_act[q] && bus.wr_addr[q] == bus.wr_addr[p])
                    wr_word[p] = DATA_W'(merge_be(MAX_W'(wr_word[p]), MAX_W'(bus.wr_data[q]),
                                                  MAX_W'(bus.wr_be[q]), BYTE_W));
            for (int q = p + 1; q < WRITE_PORTS; q++)
                if (wr_act[p] && wr_act[q] && bus.wr_addr[p] == bus.wr_addr[q]) conf_d = 1'b1;
        end
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_word[r] = mem[bus.rd_addr[r]];
            for (int q = 0; q < WRITE_PORTS; q++)
                if (USE_FWD && wr_act[q] && bus.wr_addr[q] == bus.rd_addr[r])
                    rd_word[r] = DATA_W'(merge_be(MAX_W'(rd_word[r]), MAX_W'(bus.wr_data[q]),
                                                  MAX_W'(bus.wr_be[q]), BYTE_W));
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else
            for (int p = 0; p < WRITE_PORTS; p++)
                if (wr_act[p]) mem[bus.wr_addr[p]] <= wr_word[p];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) conf_q <= 1'b0;
        else     conf_q <= conf_d;
    end

    if (BUF_READ) begin : g_buf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q   <= '0;
                rd_v_q <= '0;
            end else begin
                for (int r = 0; r < READ_PORTS; r++) begin
                    rd_v_q[r] <= bus.rd_en[r] && !busy;
                    if (bus.rd_en[r] && !busy) rd_q[r] <= rd_word[r];
                end
            end
        end
    end else begin : g_comb
        always_comb begin
            for (int r = 0; r < READ_PORTS; r++) begin
                rd_q[r]   = rd_word[r];
                rd_v_q[r] = bus.rd_en[r] && !busy;
            end
        end
    end

    assign bus.rd_data     = rd_q;
    assign bus.rd_valid    = rd_v_q;
    assign bus.busy        = busy;
    assign bus.wr_conflict = conf_q;

endmodule

// File: tb/tb_mem_block_clr.sv
// tb_mem_block_clr: scoreboard bench for write-first and read-first mem_block_clr instances
module tb_mem_block_clr;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];

    always #5 clk = ~clk;

    mem_block_clr_if #(.READ_PORTS(2), .WRITE_PORTS(2), .ADDR_W(5), .DATA_W(32), .BYTE_W(8)) if0 ();
    mem_block_clr_if #(.READ_PORTS(2), .WRITE_PORTS(1), .ADDR_W(5), .DATA_W(32), .BYTE_W(8)) if1 ();

    mem_block_clr #(
        .READ_PORTS(2), .WRITE_PORTS(2), .BUF_READ(1), .FWD(1),
        .ADDR_W(5), .DATA_W(32), .BYTE_W(8), .CLEAR_ON_RESET(1)
    ) u0 (
        .clk(clk), .rst(rst), .bus(if0)
    );

    mem_block_clr #(
        .READ_PORTS(2), .WRITE_PORTS(1), .BUF_READ(1), .FWD(0),
        .ADDR_W(5), .DATA_W(32), .BYTE_W(8), .CLEAR_ON_RESET(1)
    ) u1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        for (int k = 0; k < 4; k++)
            if (be[k]) o[8*k+:8] = d[8*k+:8];
        return o;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        if0.wr_en = '0; if0.wr_addr = '0; if0.wr_data = '0; if0.wr_be = '0;
        if0.rd_en = '0; if0.rd_addr = '0;
        if1.wr_en = '0; if1.wr_addr = '0; if1.wr_data = '0; if1.wr_be = '0;
        if1.rd_en = '0; if1.rd_addr = '0;
    endtask

    task automatic zero_models;
        for (int i = 0; i < 32; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
    endtask

    task automatic write_both(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        if0.wr_en[0] = 1'b1; if0.wr_addr[0] = a; if0.wr_data[0] = d; if0.wr_be[0] = be;
        if1.wr_en[0] = 1'b1; if1.wr_addr[0] = a; if1.wr_data[0] = d; if1.wr_be[0] = be;
        m0[a] = merge(m0[a], d, be);
        m1[a] = merge(m1[a], d, be);
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        idle();
        tick();
        tick();
        checks++;
        if (if0.busy !== 1'b1 || if1.busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b/%b expected 1/1", if0.busy, if1.busy);
        end
        checks++;
        if (if0.rd_valid !== 2'b00 || if0.rd_data !== 64'h0 || if0.wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h conflict=%b expected 00/0/0",
                     if0.rd_valid, if0.rd_data, if0.wr_conflict);
        end
        rst = 1'b0;
        n = 0;
        while (if0.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL sweep_len: got %0d cycles expected 32", n);
        end
        checks++;
        if (if1.busy !== 1'b0) begin
            errors++; $display("FAIL sweep_len_u1: got busy=%b expected 0", if1.busy);
        end
        zero_models();
    endtask

    task automatic test_clear_read;
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            if0.rd_en = 2'b11; if0.rd_addr[0] = 5'(i); if0.rd_addr[1] = 5'(31 - i);
            if1.rd_en = 2'b01; if1.rd_addr[0] = 5'(i);
            q0.push_back('{0, 32'h0});
            q0.push_back('{1, 32'h0});
            q1.push_back('{0, 32'h0});
            tick();
            while (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                if (if0.rd_valid[e.port] !== 1'b1 || if0.rd_data[e.port] !== e.data) begin
                    errors++;
                    $display("FAIL clear_read u0 p%0d i=%0d: got valid=%b data=%h expected 1/%h",
                             e.port, i, if0.rd_valid[e.port], if0.rd_data[e.port], e.data);
                end
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                checks++;
                if (if1.rd_valid[e.port] !== 1'b1 || if1.rd_data[e.port] !== e.data) begin
                    errors++;
                    $display("FAIL clear_read u1 p%0d i=%0d: got valid=%b data=%h expected 1/%h",
                             e.port, i, if1.rd_valid[e.port], if1.rd_data[e.port], e.data);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_lanes;
        exp_t e;
        write_both(5'd3, 32'hDEADBEEF, 4'b1111);
        tick();
        write_both(5'd3, 32'h00001200, 4'b0010);
        tick();
        idle();
        if0.rd_en[0] = 1'b1; if0.rd_addr[0] = 5'd3;
        if1.rd_en[1] = 1'b1; if1.rd_addr[1] = 5'd3;
        q0.push_back('{0, 32'hDEAD12EF});
        q1.push_back('{1, 32'hDEAD12EF});
        tick();
        e = q0.pop_front();
        checks++;
        if (if0.rd_data[e.port] !== e.data || if0.rd_valid[e.port] !== 1'b1) begin
            errors++; $display("FAIL byte_lanes u0: got %h expected %h", if0.rd_data[e.port], e.data);
        end
        e = q1.pop_front();
        checks++;
        if (if1.rd_data[e.port] !== e.data || if1.rd_valid[e.port] !== 1'b1) begin
            errors++; $display("FAIL byte_lanes u1: got %h expected %h", if1.rd_data[e.port], e.data);
        end
        idle();
    endtask

    task automatic test_fwd;
        exp_t e;
        write_both(5'd7, 32'hCAFEF00D, 4'b1111);
        if0.rd_en[0] = 1'b1; if0.rd_addr[0] = 5'd7;
        if1.rd_en[0] = 1'b1; if1.rd_addr[0] = 5'd7;
        q0.push_back('{0, 32'hCAFEF00D});
        q1.push_back('{0, 32'h00000000});
        tick();
        idle();
        e = q0.pop_front();
        checks++;
        if (if0.rd_data[e.port] !== e.data) begin
            errors++; $display("FAIL fwd_write_first: got %h expected %h", if0.rd_data[e.port], e.data);
        end
        e = q1.pop_front();
        checks++;
        if (if1.rd_data[e.port] !== e.data) begin
            errors++; $display("FAIL fwd_read_first: got %h expected %h", if1.rd_data[e.port], e.data);
        end
        if1.rd_en[0] = 1'b1; if1.rd_addr[0] = 5'd7;
        q1.push_back('{0, 32'hCAFEF00D});
        tick();
        idle();
        e = q1.pop_front();
        checks++;
        if (if1.rd_data[e.port] !== e.data) begin
            errors++; $display("FAIL read_first_after: got %h expected %h", if1.rd_data[e.port], e.data);
        end
    endtask

    task automatic test_conflict;
        exp_t e;
        if0.wr_en = 2'b11;
        if0.wr_addr[0] = 5'd5; if0.wr_data[0] = 32'h11111111; if0.wr_be[0] = 4'b1111;
        if0.wr_addr[1] = 5'd5; if0.wr_data[1] = 32'h22222222; if0.wr_be[1] = 4'b0011;
        m0[5] = merge(merge(m0[5], 32'h11111111, 4'b1111), 32'h22222222, 4'b0011);
        tick();
        idle();
        checks++;
        if (if0.wr_conflict !== 1'b1) begin
            errors++; $display("FAIL conflict_pulse: got %b expected 1", if0.wr_conflict);
        end
        if0.rd_en[1] = 1'b1; if0.rd_addr[1] = 5'd5;
        q0.push_back('{1, 32'h11112222});
        tick();
        idle();
        checks++;
        if (if0.wr_conflict !== 1'b0) begin
            errors++; $display("FAIL conflict_one_cycle: got %b expected 0", if0.wr_conflict);
        end
        e = q0.pop_front();
        checks++;
        if (if0.rd_data[e.port] !== e.data) begin
            errors++; $display("FAIL conflict_data: got %h expected %h", if0.rd_data[e.port], e.data);
        end
        if0.wr_en = 2'b11;
        if0.wr_addr[0] = 5'd8; if0.wr_data[0] = 32'hA5A5A5A5; if0.wr_be[0] = 4'b1111;
        if0.wr_addr[1] = 5'd9; if0.wr_data[1] = 32'h5A5A5A5A; if0.wr_be[1] = 4'b1111;
        m0[8] = 32'hA5A5A5A5;
        m0[9] = 32'h5A5A5A5A;
        tick();
        idle();
        checks++;
        if (if0.wr_conflict !== 1'b0) begin
            errors++; $display("FAIL conflict_diff_addr: got %b expected 0", if0.wr_conflict);
        end
        if0.wr_en = 2'b11;
        if0.wr_addr[0] = 5'd10; if0.wr_data[0] = 32'h01020304; if0.wr_be[0] = 4'b1111;
        if0.wr_addr[1] = 5'd10; if0.wr_data[1] = 32'hFFFFFFFF; if0.wr_be[1] = 4'b0000;
        m0[10] = 32'h01020304;
        tick();
        idle();
        checks++;
        if (if0.wr_conflict !== 1'b0) begin
            errors++; $display("FAIL conflict_zero_be: got %b expected 0", if0.wr_conflict);
        end
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        logic        exp_conf;
        logic [1:0]  we, re;
        logic [4:0]  wa [2];
        logic [4:0]  ra [2];
        logic [31:0] wd [2];
        logic [3:0]  wb [2];
        for (int it = 0; it < 60; it++) begin
            we = 2'($urandom_range(0, 3));
            re = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wa[p] = 5'($urandom_range(0, 3));
                ra[p] = 5'($urandom_range(0, 3));
                wd[p] = $urandom;
                wb[p] = 4'($urandom_range(0, 15));
                if0.wr_en[p] = we[p]; if0.wr_addr[p] = wa[p]; if0.wr_data[p] = wd[p]; if0.wr_be[p] = wb[p];
                if0.rd_en[p] = re[p]; if0.rd_addr[p] = ra[p];
            end
            exp_conf = we[0] && we[1] && wb[0] != 4'b0 && wb[1] != 4'b0 && wa[0] == wa[1];
            for (int p = 0; p < 2; p++)
                if (we[p]) m0[wa[p]] = merge(m0[wa[p]], wd[p], wb[p]);
            for (int p = 0; p < 2; p++)
                if (re[p]) q0.push_back('{p, m0[ra[p]]});
            tick();
            checks++;
            if (if0.wr_conflict !== exp_conf) begin
                errors++; $display("FAIL b2b_conflict it=%0d: got %b expected %b", it, if0.wr_conflict, exp_conf);
            end
            for (int p = 0; p < 2; p++)
                if (!re[p]) begin
                    checks++;
                    if (if0.rd_valid[p] !== 1'b0) begin
                        errors++; $display("FAIL b2b_idle_valid it=%0d p%0d: got %b expected 0", it, p, if0.rd_valid[p]);
                    end
                end
            while (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                if (if0.rd_valid[e.port] !== 1'b1 || if0.rd_data[e.port] !== e.data) begin
                    errors++;
                    $display("FAIL b2b_read it=%0d p%0d: got valid=%b data=%h expected 1/%h",
                             it, e.port, if0.rd_valid[e.port], if0.rd_data[e.port], e.data);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   n;
        write_both(5'd31, 32'h12345678, 4'b1111);
        tick();
        idle();
        if0.rd_en[0] = 1'b1; if0.rd_addr[0] = 5'd31;
        q0.push_back('{0, 32'h12345678});
        tick();
        idle();
        e = q0.pop_front();
        checks++;
        if (if0.rd_data[e.port] !== e.data) begin
            errors++; $display("FAIL pre_reset_write: got %h expected %h", if0.rd_data[e.port], e.data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (if0.busy !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_busy: got %b expected 1", if0.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (if0.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL restart_sweep_len: got %0d cycles expected 32", n);
        end
        zero_models();
        if0.rd_en[0] = 1'b1; if0.rd_addr[0] = 5'd31;
        if1.rd_en[0] = 1'b1; if1.rd_addr[0] = 5'd31;
        q0.push_back('{0, m0[31]});
        q1.push_back('{0, m1[31]});
        tick();
        idle();
        e = q0.pop_front();
        checks++;
        if (if0.rd_data[e.port] !== e.data || if0.rd_valid[e.port] !== 1'b1) begin
            errors++; $display("FAIL restart_addr31 u0: got %h expected %h", if0.rd_data[e.port], e.data);
        end
        e = q1.pop_front();
        checks++;
        if (if1.rd_data[e.port] !== e.data || if1.rd_valid[e.port] !== 1'b1) begin
            errors++; $display("FAIL restart_addr31 u1: got %h expected %h", if1.rd_data[e.port], e.data);
        end
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int   n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (if0.busy === 1'b1 && n < 100) begin
            if0.wr_en = 2'b01; if0.wr_addr[0] = 5'd2; if0.wr_data[0] = 32'hFFFFFFFF; if0.wr_be[0] = 4'b1111;
            if0.rd_en = 2'b11; if0.rd_addr[0] = 5'd2; if0.rd_addr[1] = 5'd2;
            if1.wr_en = 1'b1; if1.wr_addr[0] = 5'd2; if1.wr_data[0] = 32'hFFFFFFFF; if1.wr_be[0] = 4'b1111;
            if1.rd_en = 2'b11; if1.rd_addr[0] = 5'd2;
            tick();
            n++;
            checks++;
            if (if0.rd_valid !== 2'b00 || if1.rd_valid !== 2'b00 || if0.rd_data[0] !== 32'h0) begin
                errors++;
                $display("FAIL busy_ignore cycle %0d: got valid=%b/%b data=%h expected 00/00/0",
                         n, if0.rd_valid, if1.rd_valid, if0.rd_data[0]);
            end
        end
        idle();
        checks++;
        if (n != 32) begin
            errors++; $display("FAIL busy_sweep_len: got %0d cycles expected 32", n);
        end
        zero_models();
        if0.rd_en[0] = 1'b1; if0.rd_addr[0] = 5'd2;
        if1.rd_en[0] = 1'b1; if1.rd_addr[0] = 5'd2;
        q0.push_back('{0, m0[2]});
        q1.push_back('{0, m1[2]});
        tick();
        idle();
        e = q0.pop_front();
        checks++;
        if (if0.rd_data[e.port] !== e.data || if0.rd_valid[e.port] !== 1'b1) begin
            errors++; $display("FAIL busy_no_write u0: got %h expected %h", if0.rd_data[e.port], e.data);
        end
        e = q1.pop_front();
        checks++;
        if (if1.rd_data[e.port] !== e.data || if1.rd_valid[e.port] !== 1'b1) begin
            errors++; $display("FAIL busy_no_write u1: got %h expected %h", if1.rd_data[e.port], e.data);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_clear_read();
        test_byte_lanes();
        test_fwd();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
